hazard_ctrl_seq: RTL and testbench

//  Pipeline hazard controller for the 5-stage RV32 core with I-cache. Generalises the

---
 rtl/hazard_ctrl_seq.sv | 167 ++++++++++++++++
 tb/tb_hazard_ctrl_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_seq.sv
// Hazard controller: forwarding, load-use/busy stalls, redirects and
// I-cache miss sequencing, with saturating hazard counters.
module hazard_ctrl_seq #(
    parameter int                REG_AW   = 5,
    parameter int                RSRC_W   = 3,
    parameter logic [RSRC_W-1:0] LOAD_SRC = RSRC_W'(1),
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegwriteM,
    input  logic              RegwriteW,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [RSRC_W-1:0] resultsrcE,
    input  logic              Branch,
    input  logic              jalD,
    input  logic              ex_busy,
    input  logic              icache_miss,
    input  logic              icache_ready,
    input  logic              cnt_clr,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              icache_abort,
    output logic [CNT_W-1:0]  cnt_ldstall,
    output logic [CNT_W-1:0]  cnt_imiss,
    output logic [CNT_W-1:0]  cnt_redir
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IMISS = 2'd1,
        ABORT = 2'd2
    } state_t;

    state_t state;
    state_t state_n;

    logic lw;
    logic redir;
    logic miss_st;
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic flush_d;
    logic flush_e;
    logic flush_m;
    logic abort;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != '0) begin
            if (RegwriteM && RdM == rs) begin
                sel = 2'b10;
            end else if (RegwriteW && RdW == rs) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    assign forwardAE = fwd_sel(Rs1E);
    assign forwardBE = fwd_sel(Rs2E);

    assign lw = (resultsrcE == LOAD_SRC) && (RdE != '0)
             && (Rs1D == RdE || Rs2D == RdE);
    assign redir = (Branch || (jalD && !lw)) && !ex_busy;
    assign miss_st = (state == IMISS) || (state == ABORT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        abort   = 1'b0;
        if (ex_busy) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
        end else begin
            unique case (state)
                RUN: begin
                    if (icache_miss && !redir) state_n = IMISS;
                end
                IMISS: begin
                    if (icache_ready) begin
                        state_n = RUN;
                    end else if (redir) begin
                        abort   = 1'b1;
                        state_n = ABORT;
                    end
                end
                ABORT: begin
                    if (icache_ready) state_n = RUN;
                end
                default: state_n = RUN;
            endcase
            // a redirect overrides both the miss hold and the load-use stall
            if (redir) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else begin
                stall_f = lw || miss_st;
                stall_d = lw;
                flush_e = lw;
                flush_d = miss_st;
            end
        end
    end

    assign stallF       = rst_n && stall_f;
    assign stallD       = rst_n && stall_d;
    assign stallE       = rst_n && stall_e;
    assign flushD       = rst_n && flush_d;
    assign flushE       = rst_n && flush_e;
    assign flushM       = rst_n && flush_m;
    assign icache_abort = rst_n && abort;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_ldstall <= '0;
            cnt_imiss   <= '0;
            cnt_redir   <= '0;
        end else if (cnt_clr) begin
            cnt_ldstall <= '0;
            cnt_imiss   <= '0;
            cnt_redir   <= '0;
        end else begin
            if (lw && !ex_busy) cnt_ldstall <= sat_inc(cnt_ldstall);
            if (miss_st)        cnt_imiss   <= sat_inc(cnt_imiss);
            if (redir)          cnt_redir   <= sat_inc(cnt_redir);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_seq.sv
// Bench for hazard_ctrl_seq: rule-level reference model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_hazard_ctrl_seq;

    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic RegwriteM, RegwriteW;
    logic [4:0] RdM, RdW, RdE, Rs1E, Rs2E, Rs1D, Rs2D;
    logic [2:0] resultsrcE;
    logic Branch, jalD, ex_busy, icache_miss, icache_ready, cnt_clr;
    logic [1:0] forwardAE, forwardBE;
    logic stallF, stallD, stallE, flushD, flushE, flushM, icache_abort;
    logic [CW-1:0] cnt_ldstall, cnt_imiss, cnt_redir;

    int n_chk = 0;
    int n_pass = 0;

    // model: is a fill outstanding, and was it abandoned by a redirect
    bit fill_out;
    bit fill_dropped;
    int m_ld, m_im, m_rd;

    hazard_ctrl_seq #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegwriteM(RegwriteM), .RegwriteW(RegwriteW),
        .RdM(RdM), .RdW(RdW), .RdE(RdE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .resultsrcE(resultsrcE), .Branch(Branch), .jalD(jalD),
        .ex_busy(ex_busy), .icache_miss(icache_miss),
        .icache_ready(icache_ready), .cnt_clr(cnt_clr),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .icache_abort(icache_abort),
        .cnt_ldstall(cnt_ldstall), .cnt_imiss(cnt_imiss),
        .cnt_redir(cnt_redir)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h t=%0t",
                      nm, act, exp, $time);
    endtask

    function automatic logic [1:0] fwd_exp(input logic [4:0] rs);
        if (rs == 0) return 2'b00;
        if (RegwriteM && RdM == rs) return 2'b10;
        if (RegwriteW && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int sat(input int v);
        return (v >= MAX) ? MAX : v + 1;
    endfunction

    // one cycle: compare everything against the model, then advance it
    task automatic tick();
        bit ld, rd;
        logic [6:0] ctl;
        #1;
        if (!rst_n) begin
            fill_out = 0; fill_dropped = 0;
            m_ld = 0; m_im = 0; m_rd = 0;
        end
        ld = resultsrcE == 3'b001 && RdE != 0
             && (Rs1D == RdE || Rs2D == RdE);
        rd = (Branch || (jalD && !ld)) && !ex_busy;
        // order: stallF stallD stallE flushD flushE flushM abort
        if (!rst_n) ctl = 7'b0;
        else if (ex_busy) ctl = 7'b1110010;
        else if (rd) ctl = {5'b00011, 1'b0,
                            fill_out && !fill_dropped && !icache_ready};
        else ctl = {ld || fill_out, ld, 1'b0, fill_out, ld, 2'b00};
        chk("fwdA", 32'(forwardAE), 32'(fwd_exp(Rs1E)));
        chk("fwdB", 32'(forwardBE), 32'(fwd_exp(Rs2E)));
        chk("ctrl", 32'({stallF, stallD, stallE, flushD, flushE,
                         flushM, icache_abort}), 32'(ctl));
        chk("cnt_ld", 32'(cnt_ldstall), m_ld);
        chk("cnt_im", 32'(cnt_imiss), m_im);
        chk("cnt_rd", 32'(cnt_redir), m_rd);
        @(posedge clk);
        if (rst_n) begin
            if (cnt_clr) begin
                m_ld = 0; m_im = 0; m_rd = 0;
            end else begin
                if (ld && !ex_busy) m_ld = sat(m_ld);
                if (fill_out) m_im = sat(m_im);
                if (rd) m_rd = sat(m_rd);
            end
            if (!ex_busy) begin
                if (fill_out) begin
                    if (icache_ready) begin
                        fill_out = 0; fill_dropped = 0;
                    end else if (rd) fill_dropped = 1;
                end else if (icache_miss && !rd) fill_out = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        RegwriteM = 0; RegwriteW = 0;
        RdM = 0; RdW = 0; RdE = 0;
        Rs1E = 0; Rs2E = 0; Rs1D = 0; Rs2D = 0;
        resultsrcE = 0; Branch = 0; jalD = 0; ex_busy = 0;
        icache_miss = 0; icache_ready = 0; cnt_clr = 0;
    endtask

    initial begin
        idle();
        rst_n = 0;
        @(negedge clk);
        // reset: controls forced low, forwarding still live
        RdM = 5; RegwriteM = 1; RdW = 5; RegwriteW = 1; Rs1E = 5;
        resultsrcE = 3'b001; RdE = 7; Rs2D = 7;
        tick();
        chk("rst_fwdA", 32'(forwardAE), 32'h2);
        chk("rst_stallF", 32'(stallF), 0);
        rst_n = 1;
        #1;
        chk("lw_stall", 32'({stallF, stallD, flushE}), 32'h7);
        tick();
        Rs1E = 0; RdE = 0; Rs2D = 0;
        #1;
        chk("fwd_x0", 32'(forwardAE), 0);
        chk("lw_x0", 32'(stallF), 0);
        tick();
        RegwriteM = 0; Rs1E = 5; Rs2E = 5;
        #1;
        chk("fwd_w", 32'(forwardAE), 32'h1);
        tick();
        RegwriteM = 1; RdM = 6; Rs2E = 6; RegwriteW = 0;
        tick();
        idle();
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        // miss, fill returns 4 cycles later
        icache_miss = 1;
        tick();
        icache_miss = 0;
        #1;
        chk("imiss_hold", 32'({stallF, flushD}), 32'h3);
        repeat (3) tick();
        icache_ready = 1;
        tick();
        icache_ready = 0;
        chk("imiss_cnt", 32'(cnt_imiss), 4);
        tick();
        // redirect while a miss is pending -> abort, then wait for fill
        icache_miss = 1;
        tick();
        icache_miss = 0;
        tick();
        Branch = 1;
        #1;
        chk("abort_pulse", 32'({stallF, flushD, flushE, icache_abort}),
            32'h7);
        tick();
        Branch = 0;
        #1;
        chk("abort_hold", 32'({stallF, flushD, icache_abort}), 32'h6);
        repeat (2) tick();
        Branch = 1;
        #1;
        chk("abort_redir", 32'({stallF, icache_abort}), 0);
        tick();
        Branch = 0; icache_ready = 1;
        tick();
        icache_ready = 0;
        #1;
        chk("abort_done", 32'(stallF), 0);
        tick();
        // redirect and fill in the same cycle: no abort
        icache_miss = 1;
        tick();
        icache_miss = 0; jalD = 1; icache_ready = 1;
        #1;
        chk("redir_ready", 32'(icache_abort), 0);
        tick();
        idle();
        tick();
        // busy EX unit holds a pending jal
        jalD = 1; ex_busy = 1;
        #1;
        chk("busy", 32'({stallF, stallD, stallE, flushM, flushD}),
            32'h1e);
        repeat (3) tick();
        ex_busy = 0;
        #1;
        chk("jal_after", 32'({stallF, flushD, flushE}), 32'h3);
        tick();
        // load-use masks the jal; then load-use during a miss
        resultsrcE = 3'b001; RdE = 3; Rs1D = 3;
        tick();
        jalD = 0; icache_miss = 1;
        tick();
        icache_miss = 0;
        repeat (2) tick();
        ex_busy = 1;
        repeat (2) tick();
        idle();
        icache_ready = 1;
        tick();
        idle();
        // async reset in the middle of a miss
        icache_miss = 1;
        tick();
        icache_miss = 0;
        tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        #1;
        chk("rst_mid", 32'({stallF, flushD}), 0);
        tick();
        // counter saturation and clear priority
        Branch = 1;
        repeat (MAX + 2) tick();
        chk("sat", 32'(cnt_redir), MAX);
        cnt_clr = 1;
        tick();
        chk("clr", 32'(cnt_redir), 0);
        idle();
        tick();
        // mixed traffic against the model
        for (int i = 0; i < 400; i++) begin
            RegwriteM = 1'($urandom); RegwriteW = 1'($urandom);
            RdM = 5'($urandom_range(0, 3));
            RdW = 5'($urandom_range(0, 3));
            RdE = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3));
            Rs2E = 5'($urandom_range(0, 3));
            Rs1D = 5'($urandom_range(0, 3));
            Rs2D = 5'($urandom_range(0, 3));
            resultsrcE = 3'($urandom_range(0, 2));
            Branch = ($urandom_range(0, 7) == 0);
            jalD = ($urandom_range(0, 7) == 0);
            ex_busy = ($urandom_range(0, 5) == 0);
            icache_miss = ($urandom_range(0, 3) == 0);
            icache_ready = ($urandom_range(0, 4) == 0);
            cnt_clr = ($urandom_range(0, 39) == 0);
            rst_n = ($urandom_range(0, 149) != 0);
            tick();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
